// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response plus the decode-side FIFO head.
// The master modport is the fetch_queue's view; slave is the memory/decode environment.
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            o_IC_DataReq;
    logic [XLEN-1:0] o_IM_Addr;
    logic            i_IC_MemReady;
    logic [XLEN-1:0] i_IM_Instr;
    logic            o_valid;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_pc;
    logic            o_fault;
    logic            i_ready;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_empty;

    modport master (
        output o_IC_DataReq, o_IM_Addr, o_valid, o_instr, o_pc, o_fault, o_empty,
        input  i_IC_MemReady, i_IM_Instr, i_ready, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_IC_DataReq, o_IM_Addr, o_valid, o_instr, o_pc, o_fault, o_empty,
        output i_IC_MemReady, i_IM_Instr, i_ready, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled sequential prefetcher: issues one request at a time, buffers returned
// instructions with their PCs in a DEPTH-entry FIFO, and handles redirect/flush/fault.
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(`PC_RESET)
) (
    input logic           i_clk,
    input logic           i_rst,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic            fault;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            discard_q, discard_d;
    logic            halted_q, halted_d;
    logic            fault_pend_q, fault_pend_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          hold_q, hold_d;
    entry_t          fifo_mem [DEPTH];

    logic   transfer, valid, pop, misaligned;
    logic   mem_push, fault_push, push, issue;
    entry_t head, push_entry;

    assign transfer   = req_q & bus.i_IC_MemReady;
    assign valid      = (count_q != '0);
    assign pop        = valid & bus.i_ready;
    assign misaligned = (bus.i_redirect_pc[1:0] != 2'b00);

    // A pending fault entry waits until any discarded response has drained.
    assign mem_push   = transfer & ~discard_q & ~bus.i_redirect;
    assign fault_push = fault_pend_q & ~discard_q & ~bus.i_redirect;
    assign push       = mem_push | fault_push;

    assign push_entry = fault_push ? entry_t'{fault: 1'b1, pc: fault_pc_q, instr: '0}
                                   : entry_t'{fault: 1'b0, pc: addr_q, instr: bus.i_IM_Instr};
    assign head       = fifo_mem[rd_ptr_q];

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        req_d        = req_q;
        addr_d       = addr_q;
        fetch_pc_d   = fetch_pc_q;
        discard_d    = discard_q;
        halted_d     = halted_q;
        fault_pend_d = fault_pend_q;
        fault_pc_d   = fault_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (bus.i_redirect) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            fetch_pc_d   = bus.i_redirect_pc;
            halted_d     = misaligned;
            fault_pend_d = misaligned;
            fault_pc_d   = bus.i_redirect_pc;
            discard_d    = req_q & ~bus.i_IC_MemReady;
        end else begin
            if (transfer)   discard_d    = 1'b0;
            if (push)       wr_ptr_d     = wr_ptr_q + AW'(1);
            if (pop)        rd_ptr_d     = rd_ptr_q + AW'(1);
            if (mem_push)   fetch_pc_d   = fetch_pc_q + XLEN'(4);
            if (fault_push) fault_pend_d = 1'b0;
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // Issuing reserves a slot, so the FIFO can never be pushed while full.
        issue = ~halted_d & (~req_q | transfer) & (count_d < DEPTH_C);
        if (issue) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_d;
        end else if (transfer) begin
            req_d  = 1'b0;
        end

        hold_d = valid ? head : hold_q;
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            req_q        <= 1'b0;
            addr_q       <= PC_RESET;
            fetch_pc_q   <= PC_RESET;
            discard_q    <= 1'b0;
            halted_q     <= 1'b0;
            fault_pend_q <= 1'b0;
            fault_pc_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_q       <= '0;
        end else begin
            req_q        <= req_d;
            addr_q       <= addr_d;
            fetch_pc_q   <= fetch_pc_d;
            discard_q    <= discard_d;
            halted_q     <= halted_d;
            fault_pend_q <= fault_pend_d;
            fault_pc_q   <= fault_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
        end
    end

    // NOTE: entry storage is not reset; o_valid gates every read, so stale contents never escape.
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_entry;
    end

    assign bus.o_IC_DataReq = req_q;
    assign bus.o_IM_Addr    = addr_q;
    assign bus.o_valid      = valid;
    assign bus.o_empty      = ~valid;
    assign bus.o_instr      = valid ? head.instr : hold_q.instr;
    assign bus.o_pc         = valid ? head.pc    : hold_q.pc;
    assign bus.o_fault      = valid ? head.fault : hold_q.fault;
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised decoupled instruction-fetch unit for the next-generation ARVI core. It replaces the single-cycle datapath's direct PC-to-cache fetch with a prefetcher. The prefetcher walks sequential PCs, issues requests on the instruction-memory/cache handshake and buffers returned instructions with their PCs in a DEPTH-entry FIFO for decode. It handles redirects (branch/jump/trap/xRET) with flush, discards any in-flight response, and raises an instruction-address-misaligned fault entry.

## Interface
Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PC_RESET, `PC_RESET, first fetch address after reset.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- o_IC_DataReq  out  1  fetch request; registered.
- o_IM_Addr  out  XLEN  fetch address; registered; stable while o_IC_DataReq=1 and i_IC_MemReady=0.
- i_IC_MemReady  in  1  memory accepts request and returns data this cycle.
- i_IM_Instr  in  XLEN  instruction data, valid when i_IC_MemReady=1.
- o_valid  out  1  head entry valid.
- o_instr  out  XLEN  head instruction.
- o_pc  out  XLEN  head PC.
- o_fault  out  1  head is an instruction-address-misaligned fault entry.
- i_ready  in  1  decode consumes head when o_valid=1.
- i_redirect  in  1  single-cycle redirect strobe.
- i_redirect_pc  in  XLEN  new fetch PC.
- o_empty  out  1  FIFO occupancy is 0.

## Operation
- Reset (i_rst=0, asynchronous) values:
  - o_IC_DataReq=0, o_IM_Addr=PC_RESET.
  - o_valid=0, o_instr=0, o_pc=0, o_fault=0, o_empty=1.
  - Internal state: fetch_pc=PC_RESET, occupancy 0, discard=0, halted=0.
- Handshake: a transfer occurs in any cycle where o_IC_DataReq=1 and i_IC_MemReady=1. The request is never withdrawn or changed before acceptance, including across a redirect.
- Pop: occurs when o_valid=1 and i_ready=1.
- Push: occurs on a transfer when discard=0 and no redirect is asserted that cycle. Entry = {pc=o_IM_Addr, instr=i_IM_Instr, fault=0}; fetch_pc advances by 4 (mod 2^XLEN, wraps silently).
- Issue rule: o_IC_DataReq is set for the next cycle when all of the following hold:
  - not halted;
  - either no request is outstanding, or the current request transfers this cycle;
  - occupancy_next + 1 ≤ DEPTH, where occupancy_next = occupancy + push − pop.
  - When set, o_IM_Addr ← next fetch_pc. Back-to-back issue is allowed, so a 1-cycle memory yields one instruction per cycle.
- Overflow: the FIFO never overflows by construction. Simultaneous push and pop at full is impossible because issue reserves space.
- Redirect (priority over push/pop):
  - Occupancy ← 0 and fetch_pc ← i_redirect_pc. A pop in the same cycle is ignored.
  - If a request is outstanding and not transferring this cycle: discard ← 1. The request stays asserted with the old address until transfer, its data is dropped, discard clears, and the next request (redirect PC) is issued the following cycle.
  - If a request transfers in the redirect cycle: its data is dropped, and the new request issues next cycle.
  - A second redirect while discard=1 only updates fetch_pc.
- Misaligned redirect: if i_redirect_pc[1:0]≠0, halted ← 1 and no fetch is issued.
  - After any discard completes, one fault entry {pc=i_redirect_pc, instr=0, fault=1} is pushed.
  - Halted persists until the next redirect, which clears it.
- Head outputs: o_instr/o_pc/o_fault show the FIFO head whenever o_valid=1. They hold their last values when the FIFO is empty.

## Timing
- Fetch latency: transfer in cycle N → entry visible (o_valid=1) in cycle N+1. There is no combinational bypass from i_IM_Instr to o_instr.
- First request after reset release: o_IC_DataReq=1 in the first clock edge after i_rst rises, with o_IM_Addr=PC_RESET.
- Redirect in cycle N with no outstanding request: o_valid=0 in N+1; o_IC_DataReq=1 with o_IM_Addr=i_redirect_pc in N+1.
- Redirect with a pending request accepted in cycle M>N: new request in M+1.
- Pop in cycle N: the next entry appears in N+1. Occupancy and o_empty update in N+1.
- Reset asserted mid-transfer: all state returns to reset values immediately; the memory-side response is ignored.

## Test plan
- Reset release, memory ready every cycle, i_ready=1, PC_RESET=0x0 → requests at 0x0,0x4,0x8… back-to-back; o_pc follows one cycle behind each transfer; o_valid held at 1.
- i_ready=0, DEPTH=4, 1-cycle memory → exactly 4 transfers, then o_IC_DataReq=0 and o_empty=0. Assert i_ready for one cycle → exactly one new request issued.
- Memory ready delayed 3 cycles; redirect to 0x100 in the 1st wait cycle → old address is held until transfer, its data is not pushed, next request is at 0x100, and the first o_pc is 0x100.
- Redirect to 0x102 → no request at 0x102; one entry with o_fault=1, o_pc=0x102, o_instr=0; no further entries until a redirect to 0x200, after which fetch resumes at 0x200.
- Fetch at 0xFFFFFFFC → next request address is 0x00000000.
- Assert i_rst low for one cycle mid-request → o_IC_DataReq=0, o_valid=0 at once; after release, fetch restarts at PC_RESET.
